// File: rtl/aes_pkg.sv
// Shared AES constants and the CBC sequencer state encoding.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } cbc_state_e;

endpackage

// File: rtl/aes_cbc_dec_ctrl_if.sv
// 128-bit valid/ready block stream; master drives valid/data, slave drives ready.
interface aes_cbc_dec_ctrl_if;
  import aes_pkg::*;

  logic                   valid;
  logic                   ready;
  logic [AES_BLOCK_W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/aes_dec_watchdog.sv
// Loadable down-counter bounding how long the sequencer waits on the decipher engine.
module aes_dec_watchdog #(
  parameter int unsigned LOAD_VAL = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = $clog2(LOAD_VAL + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOAD_VAL);
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = run && (count == '0);

endmodule

// File: rtl/aes_cbc_dec_ctrl.sv
// CBC-mode sequencer for the AES decipher engine; one block in flight.
// Define AES_CBC_CHAIN_EN for CBC chaining; otherwise the block runs in ECB mode.
module aes_cbc_dec_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   keylen_cfg,
  input  logic                   key_ready,
  input  logic                   iv_load,
  input  logic [AES_BLOCK_W-1:0] iv,
  aes_cbc_dec_ctrl_if.slave      cipher,
  aes_cbc_dec_ctrl_if.master     plain,
  output logic                   dec_next,
  output logic                   dec_keylen,
  output logic [AES_BLOCK_W-1:0] dec_block,
  input  logic                   dec_ready,
  input  logic [AES_BLOCK_W-1:0] dec_result,
  output logic                   busy,
  output logic [CNT_W-1:0]       blk_cnt,
  output logic                   timeout_err
);

  cbc_state_e             state_q, state_d;
  logic                   in_rdy;
  logic                   accept;
  logic                   iv_take;
  logic                   result_take;
  logic                   out_fire;
  logic                   wd_load, wd_run, wd_expired;
  logic                   out_valid_q;
  logic [AES_BLOCK_W-1:0] out_data_q;
  logic [AES_BLOCK_W-1:0] plain_blk;

`ifdef AES_CBC_CHAIN_EN
  logic [AES_BLOCK_W-1:0] chain_q;

  assign iv_take   = iv_load && (state_q == ST_IDLE);
  assign plain_blk = dec_result ^ chain_q;

  // dec_block doubles as the captured ciphertext, so it becomes the next chaining value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else if (iv_take) begin
      chain_q <= iv;
    end else if (result_take) begin
      chain_q <= dec_block;
    end
  end
`else
  logic unused_cbc;

  assign unused_cbc = ^{iv_load, iv};
  assign iv_take    = 1'b0;
  assign plain_blk  = dec_result;
`endif

  // Gated by reset_n so the handshake reads idle while reset is held.
  assign in_rdy      = reset_n && (state_q == ST_IDLE) && key_ready && dec_ready && !iv_take;
  assign accept      = cipher.valid && in_rdy;
  assign result_take = (state_q == ST_WAIT) && dec_ready;
  assign out_fire    = (state_q == ST_OUT) && plain.ready;

  assign cipher.ready = in_rdy;
  assign plain.valid  = out_valid_q;
  assign plain.data   = out_data_q;
  assign dec_next     = (state_q == ST_ISSUE);
  assign busy         = (state_q != ST_IDLE);

  assign wd_load = (state_q == ST_GUARD);
  assign wd_run  = (state_q == ST_WAIT);

  aes_dec_watchdog #(
    .LOAD_VAL (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (wd_load),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_GUARD;
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (dec_ready) begin
          state_d = ST_OUT;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT:   if (plain.ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_block   <= '0;
      dec_keylen  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      blk_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        dec_block  <= cipher.data;
        dec_keylen <= keylen_cfg;
      end
      if (result_take) begin
        out_data_q  <= plain_blk;
        out_valid_q <= 1'b1;
      end
      if (out_fire) begin
        out_valid_q <= 1'b0;
        blk_cnt     <= blk_cnt + 1'b1;
      end
      // A result arriving on the expiry cycle still wins over the timeout.
      if ((state_q == ST_WAIT) && !dec_ready && wd_expired) begin
        timeout_err <= 1'b1;
      end else if (iv_take) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Directed-vector bench for aes_cbc_dec_ctrl using NIST SP800-38A F.2.2 blocks and an engine model.
module tb_aes_cbc_dec_ctrl;
  import aes_pkg::*;

  localparam int unsigned TO      = 255;
  localparam int unsigned CW      = 16;
  localparam int unsigned ENG_LAT = 52;

`ifdef AES_CBC_CHAIN_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  localparam logic [127:0] IV_V = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1   = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2   = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] R1   = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] R2   = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] E1   = CBC ? P1 : R1;
  localparam logic [127:0] E2   = CBC ? P2 : R2;

  logic           clk;
  logic           reset_n;
  logic           keylen_cfg;
  logic           key_ready;
  logic           iv_load;
  logic [127:0]   iv;
  logic           dec_next;
  logic           dec_keylen;
  logic [127:0]   dec_block;
  logic           dec_ready;
  logic [127:0]   dec_result;
  logic           busy;
  logic [CW-1:0]  blk_cnt;
  logic           timeout_err;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned next_cnt;
  int unsigned ov_cnt;

  aes_cbc_dec_ctrl_if cipher_if ();
  aes_cbc_dec_ctrl_if plain_if ();

  aes_cbc_dec_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .keylen_cfg  (keylen_cfg),
    .key_ready   (key_ready),
    .iv_load     (iv_load),
    .iv          (iv),
    .cipher      (cipher_if),
    .plain       (plain_if),
    .dec_next    (dec_next),
    .dec_keylen  (dec_keylen),
    .dec_block   (dec_block),
    .dec_ready   (dec_ready),
    .dec_result  (dec_result),
    .busy        (busy),
    .blk_cnt     (blk_cnt),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: ready drops one cycle after dec_next, returns after ENG_LAT cycles.
  logic [127:0] eng_blk;
  int unsigned  eng_cnt;
  bit           eng_hang;

  function automatic logic [127:0] eng_fn(input logic [127:0] c);
    case (c)
      C1:      return R1;
      C2:      return R2;
      default: return ~c;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      dec_ready  <= 1'b1;
      dec_result <= '0;
      eng_cnt    <= 0;
    end else if (dec_next) begin
      eng_cnt <= ENG_LAT;
      eng_blk <= dec_block;
    end else if (eng_cnt != 0) begin
      eng_cnt   <= eng_cnt - 1;
      dec_ready <= (eng_cnt == 1) && !eng_hang;
      if (eng_cnt == 1) dec_result <= eng_fn(eng_blk);
    end
  end

  always @(negedge clk) begin
    if (dec_next === 1'b1) next_cnt++;
    if (plain_if.valid === 1'b1) ov_cnt++;
  end

  task automatic send_blk(input logic [127:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cipher_if.valid = 1'b1;
    cipher_if.data  = d;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (cipher_if.ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    cipher_if.valid = 1'b0;
  endtask

  task automatic recv_blk(output logic [127:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (plain_if.valid === 1'b1) begin
        d  = plain_if.data;
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      plain_if.ready = 1'b1;
      @(posedge clk);
      #1;
      plain_if.ready = 1'b0;
    end
  endtask

  task automatic iv_pulse();
    @(negedge clk);
    iv      = IV_V;
    iv_load = 1'b1;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    repeat (3) @(negedge clk);
    flags = {plain_if.valid, cipher_if.ready, dec_next, dec_keylen, busy, timeout_err};
    vectors++;
    if (flags !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got %b expected %b", flags, 6'b0); end
    vectors++;
    if (plain_if.data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", plain_if.data); end
    vectors++;
    if (dec_block !== '0) begin miscompares++; $display("FAIL reset_dec_block: got %h expected 0", dec_block); end
    vectors++;
    if (blk_cnt !== '0) begin miscompares++; $display("FAIL reset_blk_cnt: got %0d expected 0", blk_cnt); end
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (cipher_if.ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready: got %b expected 1", cipher_if.ready); end
  endtask

  task automatic test_vectors();
    bit ok;
    logic [127:0] d;
    int unsigned n0;
    @(negedge clk);
    iv      = IV_V;
    iv_load = 1'b1;
    #1;
    vectors++;
    if (cipher_if.ready !== !CBC) begin miscompares++; $display("FAIL iv_load_blocks_ready: got %b expected %b", cipher_if.ready, !CBC); end
    @(posedge clk);
    #1;
    iv_load    = 1'b0;
    keylen_cfg = AES_128_BIT_KEY;
    n0 = next_cnt;
    send_blk(C1, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL v1_accept: got %b expected 1", ok); end
    vectors++;
    if (dec_block !== C1) begin miscompares++; $display("FAIL v1_dec_block: got %h expected %h", dec_block, C1); end
    vectors++;
    if ({busy, cipher_if.ready, dec_keylen} !== 3'b100) begin
      miscompares++; $display("FAIL v1_busy_rdy_keylen: got %b expected 100", {busy, cipher_if.ready, dec_keylen});
    end
    recv_blk(d, ok);
    vectors++;
    if (ok !== 1'b1 || d !== E1) begin miscompares++; $display("FAIL v1_out_data: got %h (valid seen %b) expected %h", d, ok, E1); end
    vectors++;
    if (blk_cnt !== 16'd1) begin miscompares++; $display("FAIL v1_blk_cnt: got %0d expected 1", blk_cnt); end
    vectors++;
    if (next_cnt - n0 !== 1) begin miscompares++; $display("FAIL v1_dec_next_pulses: got %0d expected 1", next_cnt - n0); end
  endtask

  task automatic test_chaining();
    bit ok;
    logic [127:0] d;
    keylen_cfg = AES_256_BIT_KEY;
    send_blk(C2, ok);
    vectors++;
    if (ok !== 1'b1 || dec_keylen !== 1'b1) begin miscompares++; $display("FAIL v2_accept_keylen: got %b/%b expected 1/1", ok, dec_keylen); end
    @(negedge clk);
    keylen_cfg = AES_128_BIT_KEY;
    key_ready  = 1'b0;
    recv_blk(d, ok);
    vectors++;
    if (ok !== 1'b1 || d !== E2) begin miscompares++; $display("FAIL v2_out_data: got %h (valid seen %b) expected %h", d, ok, E2); end
    vectors++;
    if (blk_cnt !== 16'd2) begin miscompares++; $display("FAIL v2_blk_cnt: got %0d expected 2", blk_cnt); end
    vectors++;
    if (dec_keylen !== 1'b1) begin miscompares++; $display("FAIL keylen_held: got %b expected 1", dec_keylen); end
    key_ready = 1'b1;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int unsigned bad_data, bad_rdy;
    @(negedge clk);
    plain_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    plain_if.ready = 1'b0;
    vectors++;
    if (blk_cnt !== 16'd2) begin miscompares++; $display("FAIL idle_out_ready: got %0d expected 2", blk_cnt); end
    iv_pulse();
    send_blk(C1, ok);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (plain_if.valid === 1'b1) begin seen = 1'b1; break; end
    end
    vectors++;
    if (seen !== 1'b1 || ok !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid: got %b expected 1", seen); end
    cipher_if.valid = 1'b1;
    cipher_if.data  = C2;
    bad_data = 0;
    bad_rdy  = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (plain_if.valid !== 1'b1 || plain_if.data !== E1) bad_data++;
      if (cipher_if.ready !== 1'b0) bad_rdy++;
      @(negedge clk);
    end
    cipher_if.valid = 1'b0;
    vectors++;
    if (bad_data !== 0) begin miscompares++; $display("FAIL bp_data_stable: got %0d bad cycles expected 0", bad_data); end
    vectors++;
    if (bad_rdy !== 0) begin miscompares++; $display("FAIL bp_in_ready_low: got %0d bad cycles expected 0", bad_rdy); end
    plain_if.ready = 1'b1;
    @(posedge clk);
    #1;
    plain_if.ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (blk_cnt !== 16'd3 || plain_if.valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_release: got cnt %0d valid %b expected cnt 3 valid 0", blk_cnt, plain_if.valid);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int unsigned n, ov0;
    eng_hang = 1'b1;
    ov0 = ov_cnt;
    send_blk(C1, ok);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err === 1'b1) break;
    end
    vectors++;
    if (timeout_err !== 1'b1 || n !== TO + 4) begin
      miscompares++; $display("FAIL timeout_timing: got err %b at %0d expected err 1 at %0d", timeout_err, n, TO + 4);
    end
    vectors++;
    if (busy !== 1'b0 || ov_cnt !== ov0) begin
      miscompares++; $display("FAIL timeout_idle_no_out: got busy %b out_valid cycles %0d expected 0/0", busy, ov_cnt - ov0);
    end
`ifdef AES_CBC_CHAIN_EN
    iv_pulse();
    @(negedge clk);
    vectors++;
    if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL iv_load_clears_timeout: got %b expected 0", timeout_err); end
`endif
    eng_hang = 1'b0;
    do_reset();
    @(negedge clk);
    vectors++;
    if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_clears_timeout: got %b expected 0", timeout_err); end
  endtask

  task automatic test_priority();
    bit ok;
    logic [127:0] d;
    @(negedge clk);
    iv              = IV_V;
    iv_load         = 1'b1;
    cipher_if.valid = 1'b1;
    cipher_if.data  = C1;
    #1;
    vectors++;
    if (cipher_if.ready !== !CBC) begin miscompares++; $display("FAIL prio_in_ready: got %b expected %b", cipher_if.ready, !CBC); end
    @(posedge clk);
    #1;
    iv_load         = 1'b0;
    cipher_if.valid = 1'b0;
    vectors++;
    if (busy !== !CBC) begin miscompares++; $display("FAIL prio_no_accept: got busy %b expected %b", busy, !CBC); end
`ifndef AES_CBC_CHAIN_EN
    recv_blk(d, ok);
`endif
    send_blk(C1, ok);
    recv_blk(d, ok);
    vectors++;
    if (ok !== 1'b1 || d !== E1) begin miscompares++; $display("FAIL prio_iv_loaded: got %h expected %h", d, E1); end
  endtask

  task automatic test_reset_midblock();
    bit ok;
    logic [127:0] d;
    logic [5:0] flags;
    int unsigned ov0;
    send_blk(C2, ok);
    repeat (10) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL midblock_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    flags = {plain_if.valid, cipher_if.ready, dec_next, dec_keylen, busy, timeout_err};
    vectors++;
    if (flags !== 6'b0) begin miscompares++; $display("FAIL midreset_flags: got %b expected %b", flags, 6'b0); end
    vectors++;
    if (plain_if.data !== '0 || dec_block !== '0) begin
      miscompares++; $display("FAIL midreset_data: got %h/%h expected 0/0", plain_if.data, dec_block);
    end
    vectors++;
    if (blk_cnt !== '0) begin miscompares++; $display("FAIL midreset_blk_cnt: got %0d expected 0", blk_cnt); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ov0 = ov_cnt;
    repeat (80) @(negedge clk);
    vectors++;
    if (ov_cnt !== ov0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_block_lost: got out_valid cycles %0d busy %b expected 0/0", ov_cnt - ov0, busy);
    end
    send_blk(C1, ok);
    recv_blk(d, ok);
    vectors++;
    if (ok !== 1'b1 || d !== R1 || blk_cnt !== 16'd1) begin
      miscompares++; $display("FAIL chain_cleared: got %h cnt %0d expected %h cnt 1", d, blk_cnt, R1);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    next_cnt        = 0;
    ov_cnt          = 0;
    eng_hang        = 1'b0;
    reset_n         = 1'b0;
    key_ready       = 1'b1;
    keylen_cfg      = 1'b0;
    iv_load         = 1'b0;
    iv              = '0;
    cipher_if.valid = 1'b0;
    cipher_if.data  = '0;
    plain_if.ready  = 1'b0;
    test_reset();
    test_vectors();
    test_chaining();
    test_backpressure();
    test_timeout();
    test_priority();
    test_reset_midblock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no summary expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
